// File: rtl/dmac_engine_p_pkg.sv
// dmac_engine_p_pkg: register map, status/mode bit indices and FSM states for the DMA engine
package dmac_engine_p_pkg;
  localparam logic [7:0] A_CLEAR  = 8'h00;
  localparam logic [7:0] A_START  = 8'h01;
  localparam logic [7:0] A_INT_EN = 8'h02;
  localparam logic [7:0] A_SRC    = 8'h03;
  localparam logic [7:0] A_DEST   = 8'h04;
  localparam logic [7:0] A_PUSH   = 8'h05;
  localparam logic [7:0] A_COUNT  = 8'h06;
  localparam logic [7:0] A_SIZE   = 8'h07;
  localparam logic [7:0] A_MODE   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_DONE = 4;
  localparam int M_SRC_INC = 0;
  localparam int M_DST_INC = 1;
  localparam int M_DRAIN = 2;
  typedef enum logic [2:0] {IDLE, POP, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/dmac_engine_p_desc_fifo.sv
// dmac_engine_p_desc_fifo: descriptor queue with flush and sticky dropped-push flag
module dmac_engine_p_desc_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge Clk)
    if (push_ok) mem[wp] <= din;
  always_ff @(posedge Clk) begin
    if (!reset_n || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
      if (push & full) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/dmac_engine_p.sv
// dmac_engine_p: queued read-then-write word copy engine with slave register port
module dmac_engine_p
  import dmac_engine_p_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int SIZE_W = 16,
  parameter int DEPTH = 8,
  parameter int ADDR_STEP = 1
) (
  input  logic          Clk,
  input  logic          reset_n,
  input  logic          S_sel,
  input  logic          S_wr,
  input  logic [7:0]    S_address,
  input  logic [DW-1:0] S_din,
  output logic [DW-1:0] S_dout,
  input  logic          M_grant,
  input  logic [DW-1:0] M_din,
  output logic          M_req,
  output logic          M_wr,
  output logic [AW-1:0] M_address,
  output logic [DW-1:0] M_dout,
  output logic          Interrupt
);
  localparam int EW = 2*AW + SIZE_W;
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_nx;
  logic int_en;
  logic [2:0] mode;
  logic [AW-1:0] src_r, dest_r, src, dest, h_src, h_dest;
  logic [SIZE_W-1:0] size_r, cnt, h_size;
  logic [DW-1:0] data;
  logic [EW-1:0] head;
  logic [CW-1:0] count;
  logic [4:0] status;
  logic full, empty, overflow, busy, op_done, wr, rd, clear, start, push, pop;
  assign {h_src, h_dest, h_size} = head;
  assign wr = S_sel & S_wr;
  assign rd = S_sel & ~S_wr;
  assign clear = wr && S_address == A_CLEAR && S_din[0];
  assign start = wr && S_address == A_START && S_din[0];
  assign push = wr && S_address == A_PUSH && S_din[0];
  assign busy = state inside {POP, READ, WRITE};
  assign op_done = state == DONE;
  assign pop = state == POP;
  assign status = {op_done, overflow, empty, full, busy};
  assign M_req = state inside {READ, WRITE};
  assign M_wr = state == WRITE && M_grant;
  assign M_address = state == READ ? src : state == WRITE ? dest : '0;
  assign M_dout = state == WRITE ? data : '0;
  assign Interrupt = op_done & int_en;
  dmac_engine_p_desc_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .Clk(Clk), .reset_n(reset_n), .push(push), .pop(pop), .flush(clear),
    .din({src_r, dest_r, size_r}), .dout(head), .full(full), .empty(empty),
    .overflow(overflow), .count(count)
  );
  always_comb begin
    S_dout = '0;
    if (rd)
      case (S_address)
        A_INT_EN: S_dout = DW'(int_en);
        A_SRC:    S_dout = DW'(src_r);
        A_DEST:   S_dout = DW'(dest_r);
        A_COUNT:  S_dout = DW'(count);
        A_SIZE:   S_dout = DW'(size_r);
        A_MODE:   S_dout = DW'(mode);
        A_STATUS: S_dout = DW'(status);
        default:  S_dout = '0;
      endcase
  end
  // "non-empty" after a pop means something remains behind the entry being taken
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? POP : IDLE;
      POP:   state_nx = empty ? DONE : h_size != '0 ? READ : (mode[M_DRAIN] && count > CW'(1)) ? POP : DONE;
      READ:  state_nx = M_grant ? WRITE : READ;
      WRITE: state_nx = !M_grant ? WRITE : cnt != SIZE_W'(1) ? READ : (mode[M_DRAIN] && !empty) ? POP : DONE;
      default: state_nx = state;
    endcase
    if (clear) state_nx = IDLE;
  end
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state <= IDLE;
      int_en <= 1'b0;
      mode <= '0;
      src_r <= '0;
      dest_r <= '0;
      size_r <= '0;
      src <= '0;
      dest <= '0;
      cnt <= '0;
      data <= '0;
    end else begin
      state <= state_nx;
      if (wr && !busy)
        case (S_address)
          A_INT_EN: int_en <= S_din[0];
          A_SRC:    src_r <= S_din[AW-1:0];
          A_DEST:   dest_r <= S_din[AW-1:0];
          A_SIZE:   size_r <= S_din[SIZE_W-1:0];
          A_MODE:   mode <= S_din[2:0];
          default:  ;
        endcase
      if (pop && !empty) {src, dest, cnt} <= head;
      if (state == READ && M_grant) data <= M_din;
      if (M_wr) begin
        cnt <= cnt - 1'b1;
        if (mode[M_SRC_INC]) src <= src + AW'(ADDR_STEP);
        if (mode[M_DST_INC]) dest <= dest + AW'(ADDR_STEP);
      end
    end
  end
endmodule

// File: tb/tb_dmac_engine_p.sv
// tb_dmac_engine_p: randomized scoreboard bench for dmac_engine_p
module tb_dmac_engine_p;
  import dmac_engine_p_pkg::*;
  logic Clk = 0, reset_n = 0, S_sel = 0, S_wr = 0, M_grant = 0;
  logic [7:0] S_address = 0;
  logic [31:0] S_din = 0, S_dout, M_din, M_dout;
  logic M_req, M_wr, Interrupt;
  logic [7:0] M_address;
  int pass_n = 0, total_n = 0, writes_seen = 0, gmode = 0;
  logic [31:0] mem [256];
  typedef struct {logic [7:0] s; logic [7:0] d; logic [15:0] n;} desc_t;
  desc_t descq[$];
  logic [7:0] exp_rd[$], exp_wa[$], rd_log[$];
  logic [31:0] exp_wd[$];
  logic [2:0] m_mode = 0;
  logic m_int_en = 0;

  assign M_din = mem[M_address];
  always #5 Clk = ~Clk;

  dmac_engine_p dut (
    .Clk(Clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address),
    .S_din(S_din), .S_dout(S_dout), .M_grant(M_grant), .M_din(M_din), .M_req(M_req),
    .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout), .Interrupt(Interrupt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    S_sel = 1; S_wr = 1; S_address = a; S_din = d;
    @(negedge Clk);
    S_sel = 0; S_wr = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    S_sel = 1; S_wr = 0; S_address = a;
    #1 v = S_dout;
    S_sel = 0;
    @(negedge Clk);
  endtask

  task automatic push_desc(input logic [7:0] s, input logic [7:0] d, input logic [15:0] n);
    wr(A_SRC, 32'(s)); wr(A_DEST, 32'(d)); wr(A_SIZE, 32'(n)); wr(A_PUSH, 1);
    if (descq.size() < 8) descq.push_back('{s, d, n});
  endtask

  task automatic set_mode(input logic [2:0] m);
    wr(A_MODE, 32'(m));
    m_mode = m;
  endtask

  task automatic set_int(input logic e);
    wr(A_INT_EN, 32'(e));
    m_int_en = e;
  endtask

  task automatic do_clear();
    wr(A_CLEAR, 1);
    descq.delete(); exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  // Reference: drain mode consumes every queued descriptor, otherwise just the head
  task automatic start_run();
    int k;
    logic [7:0] s, d;
    k = m_mode[M_DRAIN] ? descq.size() : (descq.size() > 0 ? 1 : 0);
    repeat (k) begin
      desc_t x;
      x = descq.pop_front();
      for (int i = 0; i < int'(x.n); i++) begin
        s = x.s + (m_mode[M_SRC_INC] ? 8'(i) : 8'd0);
        d = x.d + (m_mode[M_DST_INC] ? 8'(i) : 8'd0);
        exp_rd.push_back(s); exp_wa.push_back(d); exp_wd.push_back(mem[s]);
      end
    end
    wr(A_START, 1);
  endtask

  task automatic wait_done(input int limit);
    logic [31:0] v;
    int i;
    for (i = 0; i < limit; i++) begin
      rd(A_STATUS, v);
      if (v[ST_DONE]) break;
    end
    chk("done_timeout", 32'(i < limit), 1);
    chk("exp_drained", 32'(exp_wa.size() + exp_rd.size()), 0);
  endtask

  initial forever begin
    @(posedge Clk); #1;
    if (gmode == 1) M_grant = 1;
    else if (gmode == 2) M_grant = 1'($urandom_range(0, 1));
    else if (gmode == 0) M_grant = 0;
  end

  initial begin
    logic stall_prev;
    logic [7:0] addr_prev;
    stall_prev = 0; addr_prev = 0;
    forever begin
      @(negedge Clk);
      if (reset_n) begin
        if (M_req && !M_grant) chk("wr_gated", 32'(M_wr), 0);
        if (stall_prev && M_req) chk("addr_hold", 32'(M_address), 32'(addr_prev));
        if (M_wr) begin
          writes_seen++;
          chk("wr_req", 32'(M_req), 1);
          if (exp_wa.size() == 0) chk("extra_write", 32'(exp_wa.size()), 1);
          else begin
            chk("wr_addr", 32'(M_address), 32'(exp_wa.pop_front()));
            chk("wr_data", M_dout, exp_wd.pop_front());
          end
        end else if (M_req && M_grant) begin
          rd_log.push_back(M_address);
          if (exp_rd.size() == 0) chk("extra_read", 32'(exp_rd.size()), 1);
          else chk("rd_addr", 32'(M_address), 32'(exp_rd.pop_front()));
        end
      end
      stall_prev = reset_n && M_req && !M_grant;
      addr_prev = M_address;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int w0, n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (2) @(negedge Clk);
    chk("rst_req", 32'(M_req), 0); chk("rst_wr", 32'(M_wr), 0);
    chk("rst_addr", 32'(M_address), 0); chk("rst_dout", M_dout, 0);
    chk("rst_int", 32'(Interrupt), 0);
    reset_n = 1;
    @(negedge Clk);
    rd(A_STATUS, v); chk("rst_status", v, 32'h04);
    rd(A_COUNT, v); chk("rst_count", v, 0);

    // Drain three descriptors, the last one empty, grant withheld at first
    gmode = 0;
    push_desc(8'h0a, 8'h14, 4); push_desc(8'h1e, 8'h28, 4); push_desc(8'h28, 8'h32, 0);
    set_int(1); set_mode(3'd7);
    w0 = writes_seen;
    start_run();
    chk("t1_model_n", 32'(exp_wa.size()), 8);
    chk("t1_model_a0", 32'(exp_wa[0]), 32'h14);
    chk("t1_model_a4", 32'(exp_wa[4]), 32'h28);
    chk("t1_model_r7", 32'(exp_rd[7]), 32'h21);
    repeat (10) @(negedge Clk);
    chk("t1_req_wait", 32'(M_req), 1);
    chk("t1_addr_wait", 32'(M_address), 32'h0a);
    gmode = 1;
    wait_done(100);
    chk("t1_writes", 32'(writes_seen - w0), 8);
    chk("t1_int", 32'(Interrupt), 1);
    rd(A_COUNT, v); chk("t1_count", v, 0);
    rd(A_STATUS, v); chk("t1_status", v, 32'h14);
    do_clear();
    chk("t1_int_clr", 32'(Interrupt), 0);

    // Single-descriptor mode, fixed addresses, with latency check
    push_desc(8'h10, 8'h20, 3); push_desc(8'h30, 8'h31, 2);
    set_mode(3'd0);
    w0 = writes_seen;
    start_run();
    chk("t2_req_pop", 32'(M_req), 0);
    @(negedge Clk);
    chk("t2_req_rise", 32'(M_req), 1);
    chk("t2_addr", 32'(M_address), 32'h10);
    wait_done(100);
    chk("t2_writes", 32'(writes_seen - w0), 3);
    rd(A_COUNT, v); chk("t2_count", v, 1);
    chk("t2_count_model", v, 32'(descq.size()));
    do_clear();

    // Overflow
    for (int i = 0; i < 9; i++) push_desc(8'(i), 8'(i + 100), 1);
    rd(A_COUNT, v); chk("t3_count", v, 8);
    rd(A_STATUS, v); chk("t3_status", v, 32'h0A);
    do_clear();
    rd(A_STATUS, v); chk("t3_status_clr", v, 32'h04);

    // Grant withdrawn for five cycles inside WRITE
    gmode = 3; M_grant = 0;
    push_desc(8'h40, 8'h50, 3); set_mode(3'd3);
    w0 = writes_seen;
    start_run();
    for (int i = 0; i < 10 && !M_req; i++) @(negedge Clk);
    chk("t4_req", 32'(M_req), 1);
    @(posedge Clk); #1 M_grant = 1;
    @(posedge Clk); #1 M_grant = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("t4_stall_req", 32'(M_req), 1);
      chk("t4_stall_wr", 32'(M_wr), 0);
      chk("t4_stall_addr", 32'(M_address), 32'h50);
    end
    gmode = 1;
    wait_done(100);
    chk("t4_writes", 32'(writes_seen - w0), 3);
    do_clear();

    // Abort by CLEAR in the second word, then reset mid-transfer
    push_desc(8'h60, 8'h70, 4); set_mode(3'd3);
    w0 = writes_seen;
    start_run();
    for (int i = 0; i < 50 && writes_seen == w0; i++) @(negedge Clk);
    @(negedge Clk);
    do_clear();
    chk("t5_req", 32'(M_req), 0);
    chk("t5_int", 32'(Interrupt), 0);
    rd(A_COUNT, v); chk("t5_count", v, 0);
    rd(A_STATUS, v); chk("t5_status", v, 32'h04);
    push_desc(8'h80, 8'h90, 5);
    start_run();
    repeat (3) @(negedge Clk);
    reset_n = 0;
    @(posedge Clk); #1;
    chk("t5_rst_req", 32'(M_req), 0); chk("t5_rst_wr", 32'(M_wr), 0);
    chk("t5_rst_addr", 32'(M_address), 0); chk("t5_rst_dout", M_dout, 0);
    chk("t5_rst_int", 32'(Interrupt), 0);
    descq.delete(); exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    m_mode = 0; m_int_en = 0;
    @(negedge Clk);
    reset_n = 1;
    @(negedge Clk);

    // Address wrap at the top of the 8-bit space
    push_desc(8'hFE, 8'hF0, 4); set_mode(3'd3);
    rd_log.delete();
    start_run();
    wait_done(100);
    chk("t6_nreads", 32'(rd_log.size()), 4);
    if (rd_log.size() == 4) begin
      chk("t6_r0", 32'(rd_log[0]), 32'hFE); chk("t6_r1", 32'(rd_log[1]), 32'hFF);
      chk("t6_r2", 32'(rd_log[2]), 32'h00); chk("t6_r3", 32'(rd_log[3]), 32'h01);
    end
    do_clear();

    // Randomized descriptors, modes and grant pattern
    gmode = 2;
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++)
        push_desc(8'($urandom), 8'($urandom), 16'($urandom_range(0, 5)));
      set_int(1'($urandom_range(0, 1)));
      set_mode(3'($urandom_range(0, 7)));
      start_run();
      wait_done(400);
      chk("rnd_int", 32'(Interrupt), 32'(m_int_en));
      rd(A_COUNT, v); chk("rnd_count", v, 32'(descq.size()));
      do_clear();
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
